// File: rtl/baggage_drop_if.sv
// Purpose : sample handshake and display/actuator bundle for baggage_drop_ctrl.
// Signals : sample_valid/sample_ready handshake; sensor_temp, sensor_height,
//           descent_rate, t_lim_in sample fields; abort request;
//           t_act, t_lim, drop_en display outputs; drop_cmd, busy, drop_done status.
// Modports: master = sample source / display consumer, slave = controller.
interface baggage_drop_if;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  sensor_temp;
  logic [15:0] sensor_height;
  logic [7:0]  descent_rate;
  logic [15:0] t_lim_in;
  logic        abort;
  logic [15:0] t_act;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        drop_cmd;
  logic        busy;
  logic        drop_done;

  modport master (
    output sample_valid, sensor_temp, sensor_height, descent_rate, t_lim_in, abort,
    input  sample_ready, t_act, t_lim, drop_en, drop_cmd, busy, drop_done
  );

  modport slave (
    input  sample_valid, sensor_temp, sensor_height, descent_rate, t_lim_in, abort,
    output sample_ready, t_act, t_lim, drop_en, drop_cmd, busy, drop_done
  );
endinterface

// File: rtl/baggage_drop_ctrl.sv
// Purpose : accepts one sensor sample, computes t_act = height / descent_rate with a
//           16-step restoring divider, latches t_act/t_lim/drop_en for the display,
//           pulses drop_cmd for HOLD_CYCLES, then cools down before the next sample.
// Ports   : clk, rst_n (async active-low), bus (baggage_drop_if.slave).
module baggage_drop_ctrl #(
  parameter logic [7:0]  TEMP_MIN    = 8'd5,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned COOL_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  baggage_drop_if.slave  bus
);

  localparam int unsigned DIV_STEPS = 16;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_DIVIDE, S_DECIDE, S_HOLD, S_COOL
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic [7:0]       r_temp;
  logic [7:0]       r_div;
  logic [7:0]       r_rem;
  logic [15:0]      r_quo;
  logic [15:0]      r_tlim_cap;

  logic [15:0]      r_t_act;
  logic [15:0]      r_t_lim;
  logic             r_drop_en;
  logic             r_drop_cmd;
  logic             r_drop_done;
  logic             r_busy;

  logic             w_accept;
  logic             w_drop_en_new;
  logic             w_fire;
  logic             w_load_out;
  logic [8:0]       w_trial;
  logic [7:0]       w_sub;
  logic             w_ge;

  assign w_accept      = (r_state == S_IDLE) && bus.sample_valid;
  assign w_drop_en_new = (r_temp >= TEMP_MIN);
  assign w_fire        = w_drop_en_new && (r_quo <= r_tlim_cap);

  // One restoring step: shift next dividend bit into the partial remainder.
  // The true difference is < divisor, so an 8-bit subtract is exact.
  assign w_trial = {r_rem, r_quo[15]};
  assign w_ge    = (w_trial >= {1'b0, r_div});
  assign w_sub   = w_trial[7:0] - r_div;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and DECIDE load strobe
  always_comb begin
    w_state_nxt = r_state;
    w_load_out  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sample_valid) w_state_nxt = S_DIVIDE;
      end
      S_DIVIDE: begin
        if (bus.abort)                               w_state_nxt = S_COOL;
        else if (r_cnt == CNT_W'(DIV_STEPS - 1))     w_state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        if (bus.abort) begin
          w_state_nxt = S_COOL;
        end else begin
          w_load_out  = 1'b1;
          w_state_nxt = w_fire ? S_HOLD : S_COOL;
        end
      end
      S_HOLD: begin
        if (bus.abort)                               w_state_nxt = S_COOL;
        else if (r_cnt == CNT_W'(HOLD_CYCLES - 1))   w_state_nxt = S_COOL;
      end
      S_COOL: begin
        if (r_cnt == CNT_W'(COOL_CYCLES - 1))        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shared per-state cycle counter, restarted on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           r_cnt <= '0;
    else if ((w_state_nxt != r_state) || (r_state == S_IDLE)) r_cnt <= '0;
    else                                                  r_cnt <= r_cnt + CNT_W'(1);
  end

  // Sample capture and divider; zero divisor preloads the saturated quotient
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_temp     <= '0;
      r_div      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_tlim_cap <= '0;
    end else if (w_accept) begin
      r_temp     <= bus.sensor_temp;
      r_div      <= bus.descent_rate;
      r_rem      <= '0;
      r_quo      <= (bus.descent_rate == 8'd0) ? 16'hFFFF : bus.sensor_height;
      r_tlim_cap <= bus.t_lim_in;
    end else if ((r_state == S_DIVIDE) && (r_div != 8'd0)) begin
      r_rem      <= w_ge ? w_sub : w_trial[7:0];
      r_quo      <= {r_quo[14:0], w_ge};
    end
  end

  // Registered display and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t_act     <= '0;
      r_t_lim     <= '0;
      r_drop_en   <= 1'b0;
      r_drop_cmd  <= 1'b0;
      r_drop_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_load_out) begin
        r_t_act   <= r_quo;
        r_t_lim   <= r_tlim_cap;
        r_drop_en <= w_drop_en_new;
      end
      r_drop_cmd  <= (w_state_nxt == S_HOLD);
      r_drop_done <= (r_state == S_COOL) && (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.sample_ready = (r_state == S_IDLE);
  assign bus.t_act        = r_t_act;
  assign bus.t_lim        = r_t_lim;
  assign bus.drop_en      = r_drop_en;
  assign bus.drop_cmd     = r_drop_cmd;
  assign bus.busy         = r_busy;
  assign bus.drop_done    = r_drop_done;

endmodule
